// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: binary write counter,
// Gray pointer for the read domain, and registered full/almost-full/level/overflow.
module wptr_full_ctrl #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          w_en,
  input  logic          w_ovf_clr,
  input  logic [AW:0]   wq2_rptr,
  output logic          w_inc,
  output logic [AW-1:0] w_addr,
  output logic [AW:0]   wptr,
  output logic          w_full,
  output logic          w_almost_full,
  output logic [AW:0]   w_level,
  output logic          w_overflow
);

  localparam logic [AW:0] AFULL_T = AFULL_THRESH[AW:0];

  logic [AW:0] wbin;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin_s;
  logic [AW:0] lvl_next;
  logic [AW:0] full_ptr;

  assign w_inc      = w_en & ~w_full;
  assign wbin_next  = wbin + {{AW{1'b0}}, w_inc};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign lvl_next = wbin_next - rbin_s;
  // Full when the write pointer is exactly one lap (DEPTH) ahead of the read pointer.
  assign full_ptr = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};

  always_ff @(posedge w_clk) begin
    if (!rst_n) begin
      wbin          <= '0;
      wptr          <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      w_overflow    <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      wptr          <= wgray_next;
      w_full        <= (wgray_next == full_ptr);
      w_almost_full <= (lvl_next >= AFULL_T);
      w_level       <= lvl_next;
      if (w_en && w_full) begin
        w_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        w_overflow <= 1'b0;
      end
    end
  end

  assign w_addr = wbin[AW-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed scenarios plus randomized traffic
// compared against an occupancy-count reference model.
module tb_wptr_full_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int N     = 2 * DEPTH;

  logic          w_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          w_ovf_clr = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic          w_inc;
  logic [AW-1:0] w_addr;
  logic [AW:0]   wptr;
  logic          w_full;
  logic          w_almost_full;
  logic [AW:0]   w_level;
  logic          w_overflow;

  wptr_full_ctrl #(.DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 2)) dut (
    .w_clk(w_clk), .rst_n(rst_n), .w_en(w_en), .w_ovf_clr(w_ovf_clr),
    .wq2_rptr(wq2_rptr), .w_inc(w_inc), .w_addr(w_addr), .wptr(wptr),
    .w_full(w_full), .w_almost_full(w_almost_full), .w_level(w_level),
    .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: write count modulo 2*DEPTH and derived occupancy/flags.
  int m_wbin = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_all();
    chk("w_addr", 32'(w_addr), m_wbin % DEPTH);
    chk("wptr", 32'(wptr), 32'(to_gray(m_wbin)));
    chk("w_full", 32'(w_full), 32'(m_full));
    chk("w_almost_full", 32'(w_almost_full), 32'(m_af));
    chk("w_level", 32'(w_level), m_lvl);
    chk("w_overflow", 32'(w_overflow), 32'(m_ovf));
  endtask

  // Called at a negedge; applies inputs for one cycle and checks the result at the next negedge.
  task automatic step(input bit en, input bit clr, input int rbin);
    logic [AW:0] prev;
    bit inc;
    bit was_full;
    w_en = en;
    w_ovf_clr = clr;
    wq2_rptr = to_gray(rbin);
    #1;
    inc = en && !m_full;
    chk("w_inc", 32'(w_inc), 32'(inc));
    prev = wptr;
    @(posedge w_clk);
    was_full = m_full;
    m_wbin = (m_wbin + int'(inc)) % N;
    m_lvl  = (m_wbin - rbin + N) % N;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= DEPTH - 2);
    if (en && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge w_clk);
    check_all();
    chk("wptr_one_bit", $countones(wptr ^ prev), 32'(inc));
  endtask

  task automatic do_reset(input int cycles, input bit en, input logic [AW:0] rp);
    rst_n = 1'b0;
    w_en = en;
    w_ovf_clr = 1'b0;
    wq2_rptr = rp;
    repeat (cycles) @(posedge w_clk);
    @(negedge w_clk);
    rst_n = 1'b1;
    m_wbin = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    check_all();
  endtask

  initial begin
    int q[$];
    int r;

    // Reset with active write request and a nonzero read pointer.
    do_reset(2, 1'b1, 5'b10110);

    // Fill from empty, one request past full.
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b0, 0);
      if (i == 13) chk("af_after_13", 32'(w_almost_full), 0);
      if (i == 14) chk("af_after_14", 32'(w_almost_full), 1);
      if (i == 15) chk("full_after_15", 32'(w_full), 0);
      if (i == 16) begin
        chk("full_after_16", 32'(w_full), 1);
        chk("wptr_full", 32'(wptr), 32'h18);
        chk("level_full", 32'(w_level), 16);
      end
      if (i == 17) begin
        chk("addr_blocked", 32'(w_addr), 0);
        chk("ovf_set", 32'(w_overflow), 1);
      end
    end

    // Release by one read, then refill.
    step(1'b0, 1'b0, 1);
    chk("release_full", 32'(w_full), 0);
    chk("release_level", 32'(w_level), 15);
    step(1'b1, 1'b0, 1);
    chk("refull", 32'(w_full), 1);
    chk("refull_addr", 32'(w_addr), 1);

    // Wrap: read pointer follows the write pointer two cycles behind.
    do_reset(1, 1'b0, '0);
    q = {0, 0};
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, q[0]);
      q.push_back(m_wbin);
      void'(q.pop_front());
    end
    chk("wrap_addr", 32'(w_addr), 8);
    chk("wrap_wptr", 32'(wptr), 32'h0C);

    // Overflow set wins over clear; clear alone clears.
    do_reset(1, 1'b0, '0);
    repeat (16) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    chk("ovf_set_wins", 32'(w_overflow), 1);
    step(1'b0, 1'b1, 0);
    chk("ovf_cleared", 32'(w_overflow), 0);

    // Mid-fill reset.
    do_reset(1, 1'b0, '0);
    repeat (9) step(1'b1, 1'b0, 0);
    chk("pre_reset_addr", 32'(w_addr), 9);
    do_reset(1, 1'b1, '0);
    chk("mid_reset_wptr", 32'(wptr), 0);
    chk("mid_reset_level", 32'(w_level), 0);
    chk("mid_reset_full", 32'(w_full), 0);
    step(1'b1, 1'b0, 0);
    chk("resume_addr", 32'(w_addr), 1);

    // Randomized traffic with a read pointer that never passes the writes.
    do_reset(1, 1'b0, '0);
    r = 0;
    for (int i = 0; i < 400; i++) begin
      if (r != m_wbin && $urandom_range(0, 2) == 0) r = (r + 1) % N;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
